// File: rtl/layer_compositor.sv
// Priority compositor: the lowest-index enabled active layer wins, with 2-stage pipeline and per-frame occlusion flags.
// Optional blink of layer 0 is enabled by defining LAYER_BLINK_EN.
module layer_compositor #(
  parameter int unsigned NUM_LAYERS   = 5,
  parameter logic [23:0] BG_RGB       = 24'h000000,
  parameter int unsigned BLINK_FRAMES = 16
) (
  input  logic                             pixel_clk,
  input  logic                             rst,
  input  logic                             fsync,
  input  logic                             active,
  input  logic signed [11:0]               hpos,
  input  logic signed [11:0]               vpos,
  input  logic [NUM_LAYERS-1:0]            layer_active,
  input  logic [NUM_LAYERS*24-1:0]         layer_rgb,
  input  logic [NUM_LAYERS-1:0]            mask_in,
  input  logic                             mask_wr,
  output logic [2:0][7:0]                  pixel,
  output logic                             active_out,
  output logic signed [11:0]               hpos_out,
  output logic signed [11:0]               vpos_out,
  output logic                             fsync_out,
  output logic [$clog2(NUM_LAYERS+1)-1:0]  winner,
  output logic [NUM_LAYERS-1:0]            hidden_flags
);

  localparam int unsigned WW = $clog2(NUM_LAYERS + 1);
  localparam logic [WW-1:0] NoWin = WW'(NUM_LAYERS);

  logic blink_ok;

`ifdef LAYER_BLINK_EN
  localparam int unsigned CW = (BLINK_FRAMES > 1) ? $clog2(2 * BLINK_FRAMES) : 1;
  logic [CW-1:0] blink_cnt_q, blink_cnt_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    if (fsync) begin
      blink_cnt_d = (blink_cnt_q == CW'(2 * BLINK_FRAMES - 1)) ? '0 : blink_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) blink_cnt_q <= '0;
    else     blink_cnt_q <= blink_cnt_d;
  end

  assign blink_ok = (blink_cnt_q < CW'(BLINK_FRAMES));
`else
  // BLINK_FRAMES is kept for interface compatibility; layer 0 is never blanked here.
  assign blink_ok = (BLINK_FRAMES >= 1) || (BLINK_FRAMES == 0);
`endif

  logic [NUM_LAYERS-1:0] live_mask_q, live_mask_d;
  logic [NUM_LAYERS-1:0] pend_mask_q, pend_mask_d;
  logic [NUM_LAYERS-1:0] hidden_acc_q, hidden_acc_d;
  logic [NUM_LAYERS-1:0] hidden_flags_q, hidden_flags_d;

  logic [WW-1:0]         winner_s1_q, winner_s1_d;
  logic [23:0]           rgb_s1_q, rgb_s1_d;
  logic                  act_s1_q, act_s1_d;
  logic                  fsync_s1_q, fsync_s1_d;
  logic signed [11:0]    hpos_s1_q, hpos_s1_d;
  logic signed [11:0]    vpos_s1_q, vpos_s1_d;

  logic [23:0]           pixel_q, pixel_d;
  logic [WW-1:0]         winner_q, winner_d;
  logic                  active_out_q, active_out_d;
  logic                  fsync_out_q, fsync_out_d;
  logic signed [11:0]    hpos_out_q, hpos_out_d;
  logic signed [11:0]    vpos_out_q, vpos_out_d;

  logic [NUM_LAYERS-1:0] eff_mask, req, hits;
  logic [WW-1:0]         win_idx;
  logic [23:0]           win_rgb;
  logic                  found, higher;

  always_comb begin
    eff_mask    = live_mask_q;
    eff_mask[0] = live_mask_q[0] & blink_ok;
    req         = layer_active & eff_mask;

    win_idx = NoWin;
    win_rgb = BG_RGB;
    found   = 1'b0;
    hits    = '0;
    higher  = 1'b0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (req[i] && !found) begin
        win_idx = WW'(i);
        win_rgb = layer_rgb[i*24 +: 24];
        found   = 1'b1;
      end
      hits[i] = active & req[i] & higher;
      higher  = higher | req[i];
    end

    // A write coinciding with fsync must land at this boundary, so live takes the post-write pending value.
    pend_mask_d = mask_wr ? mask_in : pend_mask_q;
    live_mask_d = fsync ? pend_mask_d : live_mask_q;

    hidden_flags_d = hidden_flags_q;
    hidden_acc_d   = hidden_acc_q | hits;
    if (fsync) begin
      hidden_flags_d = hidden_acc_q | hits;
      hidden_acc_d   = '0;
    end

    winner_s1_d = (active && found) ? win_idx : NoWin;
    rgb_s1_d    = win_rgb;
    act_s1_d    = active;
    fsync_s1_d  = fsync;
    hpos_s1_d   = hpos;
    vpos_s1_d   = vpos;

    pixel_d      = act_s1_q ? rgb_s1_q : BG_RGB;
    winner_d     = act_s1_q ? winner_s1_q : NoWin;
    active_out_d = act_s1_q;
    fsync_out_d  = fsync_s1_q;
    hpos_out_d   = hpos_s1_q;
    vpos_out_d   = vpos_s1_q;
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      live_mask_q    <= '1;
      pend_mask_q    <= '1;
      hidden_acc_q   <= '0;
      hidden_flags_q <= '0;
      winner_s1_q    <= NoWin;
      rgb_s1_q       <= BG_RGB;
      act_s1_q       <= 1'b0;
      fsync_s1_q     <= 1'b0;
      hpos_s1_q      <= '0;
      vpos_s1_q      <= '0;
      pixel_q        <= BG_RGB;
      winner_q       <= NoWin;
      active_out_q   <= 1'b0;
      fsync_out_q    <= 1'b0;
      hpos_out_q     <= '0;
      vpos_out_q     <= '0;
    end else begin
      live_mask_q    <= live_mask_d;
      pend_mask_q    <= pend_mask_d;
      hidden_acc_q   <= hidden_acc_d;
      hidden_flags_q <= hidden_flags_d;
      winner_s1_q    <= winner_s1_d;
      rgb_s1_q       <= rgb_s1_d;
      act_s1_q       <= act_s1_d;
      fsync_s1_q     <= fsync_s1_d;
      hpos_s1_q      <= hpos_s1_d;
      vpos_s1_q      <= vpos_s1_d;
      pixel_q        <= pixel_d;
      winner_q       <= winner_d;
      active_out_q   <= active_out_d;
      fsync_out_q    <= fsync_out_d;
      hpos_out_q     <= hpos_out_d;
      vpos_out_q     <= vpos_out_d;
    end
  end

  assign pixel        = pixel_q;
  assign winner       = winner_q;
  assign active_out   = active_out_q;
  assign fsync_out    = fsync_out_q;
  assign hpos_out     = hpos_out_q;
  assign vpos_out     = vpos_out_q;
  assign hidden_flags = hidden_flags_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Self-checking bench for layer_compositor: directed scenarios plus randomized traffic against a frame-level model.
module tb_layer_compositor;

  localparam int NL = 5;
  localparam int BF = 2;
  localparam logic [23:0] BG = 24'h1A2B3C;

  typedef struct packed {
    logic [23:0] pix;
    logic [2:0]  win;
    logic        act;
    logic [11:0] h;
    logic [11:0] v;
    logic        fs;
  } out_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              fsync = 1'b0;
  logic              active = 1'b0;
  logic signed [11:0] hpos = '0, vpos = '0;
  logic [NL-1:0]     la = '0, mask_in = '0;
  logic              mask_wr = 1'b0;
  logic [NL*24-1:0]  rgb = '0;

  logic [2:0][7:0]   pixel;
  logic              active_out, fsync_out;
  logic signed [11:0] hpos_out, vpos_out;
  logic [2:0]        winner;
  logic [NL-1:0]     hidden_flags;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [NL-1:0] m_live, m_pend, m_acc, m_flags;
  int            m_cnt;
  out_t          pipe_q[$];
  out_t          exp_out;
  out_t          reset_val;

  layer_compositor #(.NUM_LAYERS(NL), .BG_RGB(BG), .BLINK_FRAMES(BF)) dut (
    .pixel_clk(clk), .rst(rst), .fsync(fsync), .active(active), .hpos(hpos), .vpos(vpos),
    .layer_active(la), .layer_rgb(rgb), .mask_in(mask_in), .mask_wr(mask_wr),
    .pixel(pixel), .active_out(active_out), .hpos_out(hpos_out), .vpos_out(vpos_out),
    .fsync_out(fsync_out), .winner(winner), .hidden_flags(hidden_flags)
  );

  always #5 clk = ~clk;

  function automatic out_t obs();
    return {pixel, winner, active_out, hpos_out, vpos_out, fsync_out};
  endfunction

  function automatic logic [23:0] color_of(int idx);
    logic [NL*24-1:0] r;
    r = rgb;
    return r[idx*24 +: 24];
  endfunction

  // One clock: the model consumes the inputs the DUT samples on this edge.
  task automatic cycle();
    logic [NL-1:0] en;
    int first;
    out_t e;
    @(posedge clk);
    if (rst) begin
      m_live = '1; m_pend = '1; m_acc = '0; m_flags = '0; m_cnt = 0;
      pipe_q.delete();
      pipe_q.push_back(reset_val);
      exp_out = reset_val;
    end else begin
      en = la & m_live;
`ifdef LAYER_BLINK_EN
      if (m_cnt >= BF) en[0] = 1'b0;
`endif
      first = NL;
      for (int i = NL - 1; i >= 0; i--) if (en[i]) first = i;
      e.pix = (active && first < NL) ? color_of(first) : BG;
      e.win = active ? 3'(first) : 3'(NL);
      e.act = active; e.h = hpos; e.v = vpos; e.fs = fsync;
      for (int i = 0; i < NL; i++)
        if (active && en[i] && ((en & ((NL'(1) << i) - NL'(1))) != '0)) m_acc[i] = 1'b1;
      if (fsync) begin
        m_flags = m_acc;
        m_acc = '0;
        m_cnt = (m_cnt + 1) % (2 * BF);
      end
      if (mask_wr) m_pend = mask_in;
      if (fsync) m_live = m_pend;
      pipe_q.push_back(e);
      exp_out = pipe_q.pop_front();
    end
    #1;
  endtask

  task automatic randomize_rgb();
    for (int i = 0; i < NL; i++) rgb[i*24 +: 24] = 24'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    checks++;
    if (obs() !== reset_val) begin errors++; $display("FAIL reset_out: got %h exp %h", obs(), reset_val); end
    checks++;
    if (hidden_flags !== '0) begin errors++; $display("FAIL reset_flags: got %b exp 00000", hidden_flags); end
    rst = 1'b0;
    cycle();
    checks++;
    if (obs() !== exp_out) begin errors++; $display("FAIL reset_hold: got %h exp %h", obs(), exp_out); end
  endtask

  task automatic test_priority();
    logic [23:0] want;
    randomize_rgb();
    want = color_of(1);
    active = 1'b1; la = 5'b01010; hpos = 12'sd10; vpos = 12'sd3;
    cycle(); la = '0;
    cycle();
    checks++;
    if (winner !== 3'd1 || pixel !== want) begin
      errors++; $display("FAIL priority: got win %0d pix %h exp win 1 pix %h", winner, pixel, want);
    end
    checks++;
    if (obs() !== exp_out) begin errors++; $display("FAIL priority_model: got %h exp %h", obs(), exp_out); end
  endtask

  task automatic test_background();
    active = 1'b1; la = '0;
    cycle(); cycle();
    checks++;
    if (winner !== 3'd5 || pixel !== BG) begin
      errors++; $display("FAIL background: got win %0d pix %h exp win 5 pix %h", winner, pixel, BG);
    end
    active = 1'b0; la = 5'b00001;
    cycle(); cycle();
    checks++;
    if (winner !== 3'd5 || pixel !== BG || active_out !== 1'b0) begin
      errors++; $display("FAIL blanking: got win %0d pix %h act %b exp win 5 pix %h act 0", winner, pixel, active_out, BG);
    end
  endtask

  task automatic test_mask_boundary();
    active = 1'b1; la = 5'b00110;
    mask_wr = 1'b1; mask_in = 5'b11101;
    cycle(); mask_wr = 1'b0;
    for (int k = 0; k < 4; k++) cycle();
    checks++;
    if (winner !== 3'd1) begin errors++; $display("FAIL mask_midframe: got win %0d exp 1", winner); end
    fsync = 1'b1;
    cycle(); fsync = 1'b0;
    cycle();
    checks++;
    if (winner !== 3'd1) begin errors++; $display("FAIL mask_fsync_cycle: got win %0d exp 1", winner); end
    cycle(); cycle();
    checks++;
    if (winner !== 3'd2 || pixel !== color_of(2)) begin
      errors++; $display("FAIL mask_applied: got win %0d pix %h exp win 2 pix %h", winner, pixel, color_of(2));
    end
  endtask

  task automatic test_occlusion();
    active = 1'b1; la = '0;
    mask_wr = 1'b1; mask_in = '1; fsync = 1'b1;
    cycle(); mask_wr = 1'b0; fsync = 1'b0;
    la = 5'b01100;
    cycle(); la = '0;
    cycle(); cycle();
    fsync = 1'b1;
    cycle(); fsync = 1'b0;
    checks++;
    if (hidden_flags !== 5'b01000) begin errors++; $display("FAIL occlusion: got %b exp 01000", hidden_flags); end
    la = 5'b00100;
    cycle(); cycle(); la = '0;
    fsync = 1'b1;
    cycle(); fsync = 1'b0;
    checks++;
    if (hidden_flags !== 5'b00000) begin errors++; $display("FAIL occlusion_clear: got %b exp 00000", hidden_flags); end
  endtask

  task automatic random_traffic(int n, string tag);
    for (int k = 0; k < n; k++) begin
      active  = ($urandom_range(0, 7) != 0);
      la      = NL'($urandom);
      hpos    = 12'($urandom);
      vpos    = 12'($urandom);
      fsync   = ($urandom_range(0, 19) == 0);
      mask_wr = ($urandom_range(0, 14) == 0);
      mask_in = NL'($urandom);
      if ($urandom_range(0, 3) == 0) randomize_rgb();
      cycle();
      checks++;
      if (obs() !== exp_out) begin errors++; $display("FAIL %s_out[%0d]: got %h exp %h", tag, k, obs(), exp_out); end
      checks++;
      if (hidden_flags !== m_flags) begin errors++; $display("FAIL %s_flags[%0d]: got %b exp %b", tag, k, hidden_flags, m_flags); end
    end
    fsync = 1'b0; mask_wr = 1'b0;
  endtask

  task automatic test_random();
    random_traffic(400, "random");
  endtask

  task automatic test_reset_mid();
    active = 1'b1; la = 5'b11111;
    mask_wr = 1'b1; mask_in = 5'b00000; fsync = 1'b1;
    cycle(); mask_wr = 1'b0; fsync = 1'b0;
    cycle(); cycle();
    rst = 1'b1;
    cycle();
    checks++;
    if (obs() !== reset_val || hidden_flags !== '0) begin
      errors++; $display("FAIL reset_mid: got %h/%b exp %h/00000", obs(), hidden_flags, reset_val);
    end
    rst = 1'b0; la = 5'b01010; hpos = 12'sd77;
    cycle();
    checks++;
    if (winner !== 3'd5 || active_out !== 1'b0) begin
      errors++; $display("FAIL reset_mid_flush: got win %0d act %b exp win 5 act 0", winner, active_out);
    end
    cycle();
    checks++;
    if (winner !== 3'd1 || active_out !== 1'b1 || hpos_out !== 12'sd77) begin
      errors++; $display("FAIL reset_mid_mask: got win %0d act %b h %0d exp win 1 act 1 h 77", winner, active_out, hpos_out);
    end
    random_traffic(100, "post_reset");
  endtask

`ifdef LAYER_BLINK_EN
  task automatic test_blink();
    logic [2:0] want;
    rst = 1'b1; cycle(); rst = 1'b0;
    active = 1'b1; la = 5'b00011;
    for (int f = 0; f <= 4; f++) begin
      if (f > 0) begin fsync = 1'b1; cycle(); fsync = 1'b0; end
      cycle(); cycle(); cycle();
      want = (f < 2 || f == 4) ? 3'd0 : 3'd1;
      checks++;
      if (winner !== want) begin errors++; $display("FAIL blink_frame%0d: got win %0d exp %0d", f, winner, want); end
    end
  endtask
`endif

  initial begin
    reset_val = '{pix: BG, win: 3'(NL), act: 1'b0, h: '0, v: '0, fs: 1'b0};
    m_live = '1; m_pend = '1; m_acc = '0; m_flags = '0; m_cnt = 0;
    exp_out = reset_val;
    test_reset();
    test_priority();
    test_background();
    test_mask_boundary();
    test_occlusion();
    test_random();
    test_reset_mid();
`ifdef LAYER_BLINK_EN
    test_blink();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
